// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, scheduler state type and index-width helper for NN layer blocks
package nn_pkg;
  localparam int ACT_W = 8;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/issue_tag_pipe.sv
// issue_tag_pipe: DEPTH-stage shift of {valid, node index} tracking issues through the datapath
module issue_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [IW-1:0] in_idx,
  output logic          out_valid,
  output logic [IW-1:0] out_idx
);
  logic [DEPTH-1:0]         v;
  logic [DEPTH-1:0][IW-1:0] idx;
  always_ff @(posedge clk) begin
    if (reset) begin
      v   <= '0;
      idx <= '0;
    end else begin
      v[0]   <= in_valid;
      idx[0] <= in_idx;
      for (int i = 1; i < DEPTH; i++) begin
        v[i]   <= v[i-1];
        idx[i] <= idx[i-1];
      end
    end
  end
  assign out_valid = v[DEPTH-1];
  assign out_idx   = idx[DEPTH-1];
endmodule

// File: rtl/fc_layer_sched.sv
// fc_layer_sched: time-multiplexes all nodes of an FC layer onto one pipelined neuron datapath
module fc_layer_sched import nn_pkg::*; #(
  parameter int NUM_IN    = 10,
  parameter int NUM_NODES = 4,
  parameter int PIPE_LAT  = 3,
  parameter int ACT_W     = nn_pkg::ACT_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [ACT_W*NUM_IN-1:0]        in_data,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [ACT_W*NUM_IN-1:0]        node_act,
  output logic [idx_w(NUM_NODES)-1:0]    node_sel,
  output logic                           node_issue,
  input  logic [ACT_W-1:0]               node_result,
  output logic [ACT_W*NUM_NODES-1:0]     out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           busy
);
  localparam int SW = idx_w(NUM_NODES);
  localparam logic [SW-1:0] LAST = SW'(NUM_NODES - 1);
  state_t state, state_nx;
  logic          tag_v;
  logic [SW-1:0] tag_idx;
  always_ff @(posedge clk) state <= reset ? S_IDLE : state_nx;
  always_comb begin
    state_nx   = state;
    in_ready   = state == S_IDLE && !reset;
    node_issue = state == S_ISSUE;
    out_valid  = state == S_DONE;
    busy       = state != S_IDLE;
    case (state)
      S_IDLE:  state_nx = in_valid ? S_ISSUE : S_IDLE;
      S_ISSUE: state_nx = node_sel == LAST ? S_DRAIN : S_ISSUE;
      S_DRAIN: state_nx = tag_v && tag_idx == LAST ? S_DONE : S_DRAIN;
      S_DONE:  state_nx = out_ready ? S_IDLE : S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end
  // node_sel doubles as the issue counter and holds at the last index through DRAIN
  always_ff @(posedge clk) begin
    if (reset) begin
      node_act <= '0;
      node_sel <= '0;
      out_data <= '0;
    end else begin
      if (state == S_IDLE && in_valid) begin
        node_act <= in_data;
        node_sel <= '0;
      end else if (state == S_ISSUE && node_sel != LAST) begin
        node_sel <= node_sel + 1'b1;
      end
      if (tag_v) out_data[ACT_W*tag_idx +: ACT_W] <= node_result;
    end
  end
  issue_tag_pipe #(.DEPTH(PIPE_LAT), .IW(SW)) u_tags (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (node_issue),
    .in_idx    (node_sel),
    .out_valid (tag_v),
    .out_idx   (tag_idx)
  );
endmodule

// File: tb/tb_fc_layer_sched.sv
// tb_fc_layer_sched: random vectors through two scheduler instances with stub datapaths and a vector-level model
module tb_fc_layer_sched;
  logic clk = 0;
  logic rst;
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0;
  bit dp_m;
  logic [79:0] a_in_data, a_node_act, b_in_data, b_node_act;
  logic a_in_valid, a_in_ready, a_node_issue, a_out_valid, a_out_ready, a_busy;
  logic b_in_valid, b_in_ready, b_node_issue, b_out_valid, b_out_ready, b_busy;
  logic [1:0]  a_node_sel;
  logic [0:0]  b_node_sel;
  logic [7:0]  a_node_result, b_node_result, b_out_data;
  logic [31:0] a_out_data;
  fc_layer_sched #(.NUM_IN(10), .NUM_NODES(4), .PIPE_LAT(3), .ACT_W(8)) dut_a (
    .clk(clk), .reset(rst), .in_data(a_in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .node_act(a_node_act), .node_sel(a_node_sel), .node_issue(a_node_issue), .node_result(a_node_result),
    .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .busy(a_busy));
  fc_layer_sched #(.NUM_IN(10), .NUM_NODES(1), .PIPE_LAT(1), .ACT_W(8)) dut_b (
    .clk(clk), .reset(rst), .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .node_act(b_node_act), .node_sel(b_node_sel), .node_issue(b_node_issue), .node_result(b_node_result),
    .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .busy(b_busy));
  function automatic logic [7:0] dp(input logic [79:0] act, input int sel, input bit m);
    return m ? (act[8*sel +: 8] ^ 8'(sel * 29 + 90)) : 8'(16 + sel);
  endfunction
  // stub datapaths: result appears PIPE_LAT cycles after issue, junk otherwise
  logic [2:0]      a_pvv;
  logic [2:0][7:0] a_pv;
  logic            b_pvv;
  logic [7:0]      b_pv;
  always @(posedge clk) begin
    a_pvv <= {a_pvv[1:0], a_node_issue};
    a_pv  <= {a_pv[1:0], dp(a_node_act, int'(a_node_sel), dp_m)};
    b_pvv <= b_node_issue;
    b_pv  <= dp(b_node_act, int'(b_node_sel), dp_m);
  end
  assign a_node_result = a_pvv[2] ? a_pv[2] : 8'hEE;
  assign b_node_result = b_pvv ? b_pv : 8'hEE;
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [79:0] rnd80();
    return {16'($urandom), $urandom, $urandom};
  endfunction
  task automatic run_a(input bit m, input int hold);
    logic [79:0] v;
    logic [31:0] e;
    v = rnd80();
    dp_m = m;
    for (int n = 0; n < 4; n++) e[8*n +: 8] = dp(v, n, m);
    a_in_data = v;
    a_in_valid = 1;
    for (int i = 0; i < 20 && !a_in_ready; i++) tick();
    chk("a_rdy_wait", a_in_ready, 1);
    tick();
    for (int k = 1; k <= 8; k++) begin
      chk("a_issue", a_node_issue, k <= 4);
      if (k <= 4) chk("a_sel", a_node_sel, k - 1);
      chk("a_act", a_node_act, v);
      chk("a_oval", a_out_valid, k == 8);
      chk("a_busy", a_busy, 1);
      a_in_data = rnd80();
      a_in_valid = k < 8 ? 1'($urandom) : 1'b0;
      if (k < 8) tick();
    end
    chk("a_out", a_out_data, e);
    for (int j = 0; j < hold; j++) begin
      tick();
      chk("a_hold_val", a_out_valid, 1);
      chk("a_hold_data", a_out_data, e);
      chk("a_hold_rdy", a_in_ready, 0);
    end
    a_out_ready = 1;
    tick();
    chk("a_idle_rdy", a_in_ready, 1);
    chk("a_idle_val", a_out_valid, 0);
    chk("a_idle_busy", a_busy, 0);
    a_out_ready = 0;
  endtask
  task automatic run_b();
    logic [79:0] v;
    v = rnd80();
    dp_m = 1;
    b_in_data = v;
    b_in_valid = 1;
    for (int i = 0; i < 20 && !b_in_ready; i++) tick();
    chk("b_rdy_wait", b_in_ready, 1);
    tick();
    b_in_valid = 0;
    chk("b_issue1", b_node_issue, 1);
    chk("b_sel", b_node_sel, 0);
    chk("b_oval1", b_out_valid, 0);
    tick();
    chk("b_issue2", b_node_issue, 0);
    chk("b_oval2", b_out_valid, 0);
    chk("b_busy", b_busy, 1);
    tick();
    chk("b_oval3", b_out_valid, 1);
    chk("b_out", b_out_data, dp(v, 0, 1));
    b_out_ready = 1;
    tick();
    chk("b_idle_rdy", b_in_ready, 1);
    chk("b_idle_val", b_out_valid, 0);
    b_out_ready = 0;
  endtask
  initial begin
    logic [79:0] v;
    logic [31:0] e;
    logic [31:0] q[$];
    int last, got;
    rst = 1;
    a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
    b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
    repeat (3) tick();
    chk("rst_rdy", a_in_ready, 0);
    chk("rst_oval", a_out_valid, 0);
    chk("rst_issue", a_node_issue, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_out", a_out_data, 0);
    chk("rst_act", a_node_act, 0);
    chk("rst_sel", a_node_sel, 0);
    rst = 0;
    tick();
    chk("rst_rel_rdy", a_in_ready, 1);
    run_a(0, 20);
    chk("a_fixed_out", a_out_data, 32'h13121110);
    for (int r = 0; r < 3; r++) run_a(1, int'($urandom_range(0, 4)));
    // reset during ISSUE once node 1 is on the bus
    dp_m = 1;
    a_in_data = rnd80();
    a_in_valid = 1;
    for (int i = 0; i < 20 && !a_in_ready; i++) tick();
    chk("mid_rdy_wait", a_in_ready, 1);
    tick();
    a_in_valid = 0;
    tick();
    chk("mid_sel1", a_node_sel, 1);
    rst = 1;
    tick();
    chk("mid_issue", a_node_issue, 0);
    chk("mid_oval", a_out_valid, 0);
    chk("mid_out", a_out_data, 0);
    chk("mid_busy", a_busy, 0);
    rst = 0;
    tick();
    chk("mid_rdy", a_in_ready, 1);
    run_a(1, 1);
    // back-to-back with both handshakes held high
    dp_m = 1;
    a_out_ready = 1;
    a_in_valid = 1;
    last = -1;
    got = 0;
    for (int cyc = 0; cyc < 80 && got < 5; cyc++) begin
      if (a_out_valid) begin
        got++;
        if (q.size() == 0) chk("b2b_spurious", a_out_valid, 0);
        else chk("b2b_out", a_out_data, q.pop_front());
      end
      if (a_in_ready) begin
        if (last >= 0) chk("b2b_gap", cyc - last, 9);
        last = cyc;
        v = rnd80();
        a_in_data = v;
        for (int n = 0; n < 4; n++) e[8*n +: 8] = dp(v, n, 1);
        q.push_back(e);
      end
      tick();
    end
    chk("b2b_count", got, 5);
    a_in_valid = 0;
    repeat (12) tick();
    a_out_ready = 0;
    chk("b2b_end_idle", a_busy, 0);
    for (int r = 0; r < 3; r++) run_b();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fc_layer_sched.md
# fc_layer_sched

Time-multiplexing scheduler for a fully-connected layer built on one shared pipelined neuron datapath (8-bit activations, fixed per-node weights, ReLU, 8-bit output). It accepts one input activation vector through a valid/ready handshake and holds it stable on the datapath operands. It then issues every output node of the layer back-to-back, one per cycle, by node index, and collects the returned activations into an output vector. It sits between consecutive layers and chains layer-to-layer through matching valid/ready handshakes.

## Interface
- NUM_IN, 10, activations per input vector
- NUM_NODES, 4, output nodes sequenced per vector (≥1)
- PIPE_LAT, 3, cycles from issue to node_result valid (≥1)
- ACT_W, 8, activation width
- clk  in  1  rising-edge clock; single clock domain
- reset  in  1  synchronous, active-high
- in_data  in  ACT_W*NUM_IN  input vector; element k at bits [ACT_W*k +: ACT_W]
- in_valid  in  1  input vector offered
- in_ready  out  1  scheduler can accept; reset 0, then 1 in IDLE
- node_act  out  ACT_W*NUM_IN  latched vector to datapath operands; reset 0
- node_sel  out  clog2(NUM_NODES) (min 1)  weight-set/node index of current issue; reset 0
- node_issue  out  1  issue strobe; reset 0
- node_result  in  ACT_W  datapath output, sampled PIPE_LAT cycles after issue
- out_data  out  ACT_W*NUM_NODES  result vector; node n at [ACT_W*n +: ACT_W]; reset 0
- out_valid  out  1  result vector valid; reset 0
- out_ready  in  1  downstream accepts
- busy  out  1  high in any state except IDLE; reset 0

## Operation
- States: IDLE, ISSUE, DRAIN, DONE. Reset forces IDLE. It also clears the issue counter, the tag pipe and out_data.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_data into node_act, clear issue counter, go to ISSUE.
- ISSUE: node_issue=1, node_sel=issue counter (0..NUM_NODES-1, incrementing each cycle). After issuing NUM_NODES-1, go to DRAIN.
- DRAIN: node_issue=0. Wait until the last tag leaves the tag pipe, then go to DONE.
- Tag pipe: PIPE_LAT-deep shift of {valid, node index}, loaded every cycle with {node_issue, node_sel}. When the output tag is valid, write node_result into out_data slot [index].
- DONE: out_valid=1, out_data stable. On out_ready, go to IDLE.
- node_act holds its value from the latch in IDLE until the next accepted vector. It never changes during ISSUE or DRAIN.
- in_valid is ignored outside IDLE. in_ready=0 in DONE, so a new vector arriving with out_ready is accepted one cycle later, in IDLE.
- The scheduler performs no arithmetic on results; node_result is stored verbatim.
- A NUM_NODES=1 layer goes ISSUE → DRAIN after one cycle.
- Reset mid-operation aborts the vector. Tags in flight are discarded. out_valid and node_issue are 0 on the next cycle.

## Timing
- Accept edge E. Issue cycles are E+1 … E+NUM_NODES.
- Node n is captured at the end of cycle E+1+n+PIPE_LAT.
- out_valid rises in cycle E+1+NUM_NODES+PIPE_LAT. Accept-to-valid latency is 1+NUM_NODES+PIPE_LAT cycles.
- Throughput: one vector per 2+NUM_NODES+PIPE_LAT cycles with out_ready tied high.
- DONE→IDLE takes one edge after out_ready.

## Structure
- Shared package nn_pkg: ACT_W, the state enum type, and a clog2 helper for the node index width.
- One sub-module, issue_tag_pipe: parameterised PIPE_LAT-deep {valid, index} shift register with synchronous reset.

## Test plan
- Single vector: NUM_NODES=4, PIPE_LAT=3, a stub datapath returning 8'h10+sel. Accept at E → node_issue high E+1..E+4 with sel 0..3; out_valid at E+8; out_data=32'h13121110.
- Backpressure: hold out_ready=0 for 20 cycles → out_valid stays 1, out_data stable, in_ready=0. Raise out_ready → IDLE and in_ready=1 on the next cycle.
- Operand stability: toggle in_data every cycle during ISSUE/DRAIN → node_act equals the accepted vector throughout.
- Back-to-back: in_valid=1 and out_ready=1 continuously → vectors accepted every 9 cycles, results in order.
- Reset mid-ISSUE (after sel=1): next cycle node_issue=0, out_valid=0, out_data=0. A fresh vector then completes normally with no stale captures.
- NUM_NODES=1, PIPE_LAT=1 instance: accept at E → single issue at E+1, out_valid at E+3.
